// File: rtl/pit_seq_pkg.sv
// PIT reload sequencer shared types: FSM state encoding and the
// PIT modulo-register write strobe patterns.
package pit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    LOAD_LO = 2'd2,
    LOAD_HI = 2'd3
  } seq_state_t;

  localparam logic [3:0] WR_NONE     = 4'b0000;
  localparam logic [3:0] WR_MOD_FULL = 4'b1100;
  localparam logic [3:0] WR_MOD_LO   = 4'b0100;
  localparam logic [3:0] WR_MOD_HI   = 4'b1000;

  // Next table index: wraps to 0 once idx reaches (or passed) len.
  function automatic logic [4:0] seq_adv(
    input logic [4:0] idx,
    input logic [4:0] len
  );
    return (idx >= len) ? 5'd0 : idx + 5'd1;
  endfunction

endpackage

// File: rtl/pit_seq_tbl.sv
// Reload table: TBL_DEPTH x COUNT_SIZE registers, one write port,
// one asynchronous read port (same-cycle read of a written entry sees the
// old value). Ports: bus_clk, async_rst_b, sync_reset, we/waddr/wdata,
// raddr/rdata. Contents clear on either reset.
module pit_seq_tbl #(
  parameter int COUNT_SIZE = 16,
  parameter int TBL_DEPTH  = 8,
  localparam int TBL_AW    = $clog2(TBL_DEPTH)
) (
  input  logic                  bus_clk,
  input  logic                  async_rst_b,
  input  logic                  sync_reset,
  input  logic                  we,
  input  logic [TBL_AW-1:0]     waddr,
  input  logic [COUNT_SIZE-1:0] wdata,
  input  logic [TBL_AW-1:0]     raddr,
  output logic [COUNT_SIZE-1:0] rdata
);

  logic [COUNT_SIZE-1:0] mem [TBL_DEPTH];

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      for (int i = 0; i < TBL_DEPTH; i++)
        mem[i] <= '0;
    end else if (sync_reset) begin
      for (int i = 0; i < TBL_DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pit_reload_seq.sv
// PIT reload sequencer: on each rollover writes the next modulo table
// entry through the shared PIT register write port; host always wins.
// Ports: bus_clk, async_rst_b, sync_reset, host_wdata/host_wregs in,
// write_bus/write_regs out, cnt_flag_o, seq_en, seq_len, tbl_we/addr/wdata,
// ovr_clr, seq_idx, seq_busy, seq_ovr, seq_wrap, seq_irq_o.
// Optional: define PIT_SEQ_IRQ_EN for the sticky wrap interrupt.
module pit_reload_seq
  import pit_seq_pkg::*;
#(
  parameter int COUNT_SIZE = 16,
  parameter int DWIDTH     = 16,
  parameter int TBL_DEPTH  = 8,
  localparam int TBL_AW    = $clog2(TBL_DEPTH)
) (
  input  logic                  bus_clk,
  input  logic                  async_rst_b,
  input  logic                  sync_reset,
  input  logic [DWIDTH-1:0]     host_wdata,
  input  logic [3:0]            host_wregs,
  output logic [DWIDTH-1:0]     write_bus,
  output logic [3:0]            write_regs,
  input  logic                  cnt_flag_o,
  input  logic                  seq_en,
  input  logic [TBL_AW-1:0]     seq_len,
  input  logic                  tbl_we,
  input  logic [TBL_AW-1:0]     tbl_addr,
  input  logic [COUNT_SIZE-1:0] tbl_wdata,
  input  logic                  ovr_clr,
  output logic [TBL_AW-1:0]     seq_idx,
  output logic                  seq_busy,
  output logic                  seq_ovr,
  output logic                  seq_wrap,
  output logic                  seq_irq_o
);

  seq_state_t state, state_nxt;

  logic [COUNT_SIZE-1:0] tbl_rd;
  logic [3:0]            seq_regs;
  logic [DWIDTH-1:0]     seq_bus;
  logic                  host_act;
  logic                  grant;
  logic                  adv;
  logic                  ovr_set;
  logic [TBL_AW-1:0]     idx_adv;
  logic [4:0]            adv_w;

  pit_seq_tbl #(
    .COUNT_SIZE (COUNT_SIZE),
    .TBL_DEPTH  (TBL_DEPTH)
  ) u_tbl (
    .bus_clk     (bus_clk),
    .async_rst_b (async_rst_b),
    .sync_reset  (sync_reset),
    .we          (tbl_we),
    .waddr       (tbl_addr),
    .wdata       (tbl_wdata),
    .raddr       (seq_idx),
    .rdata       (tbl_rd)
  );

  assign host_act = |host_wregs;
  assign grant    = !host_act;
  assign seq_busy = (state != IDLE);
  assign ovr_set  = cnt_flag_o && seq_en && seq_busy;

  assign adv_w   = seq_adv(5'(seq_idx), 5'(seq_len));
  assign idx_adv = adv_w[TBL_AW-1:0];

  // Strobes only issue while enabled; a drop of seq_en silences the
  // port in the same cycle and sends the FSM home.
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    seq_regs  = WR_NONE;
    seq_bus   = '0;
    if (!seq_en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (cnt_flag_o)
            state_nxt = (DWIDTH == 16) ? LOAD_W : LOAD_LO;
        end
        LOAD_W: begin
          seq_regs = WR_MOD_FULL;
          seq_bus  = DWIDTH'(tbl_rd);
          if (grant) begin
            state_nxt = IDLE;
            adv       = 1'b1;
          end
        end
        LOAD_LO: begin
          seq_regs = WR_MOD_LO;
          seq_bus  = DWIDTH'(tbl_rd[7:0]);
          if (grant)
            state_nxt = LOAD_HI;
        end
        LOAD_HI: begin
          seq_regs = WR_MOD_HI;
          seq_bus  = DWIDTH'(tbl_rd[15:8]);
          if (grant) begin
            state_nxt = IDLE;
            adv       = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign write_regs = host_act ? host_wregs : seq_regs;
  assign write_bus  = host_act ? host_wdata : seq_bus;

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      state    <= IDLE;
      seq_idx  <= '0;
      seq_ovr  <= 1'b0;
      seq_wrap <= 1'b0;
    end else if (sync_reset) begin
      state    <= IDLE;
      seq_idx  <= '0;
      seq_ovr  <= 1'b0;
      seq_wrap <= 1'b0;
    end else begin
      state    <= state_nxt;
      seq_wrap <= adv && (idx_adv == '0);
      seq_ovr  <= ovr_set | (seq_ovr & ~ovr_clr);
      if (!seq_en)
        seq_idx <= '0;
      else if (adv)
        seq_idx <= idx_adv;
    end
  end

`ifdef PIT_SEQ_IRQ_EN
  logic irq_q;

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b)
      irq_q <= 1'b0;
    else if (sync_reset)
      irq_q <= 1'b0;
    else
      irq_q <= seq_wrap | (irq_q & ~ovr_clr);
  end

  assign seq_irq_o = irq_q;
`else
  assign seq_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_pit_reload_seq.sv
// Bench for pit_reload_seq: a 16-bit and an 8-bit bus instance share
// stimulus; both are checked every cycle against a write-count model.
module tb_pit_reload_seq;

  localparam int AW = 3;

  logic          bus_clk = 1'b0;
  logic          async_rst_b = 1'b0;
  logic          sync_reset = 1'b0;
  logic [15:0]   host_wdata = '0;
  logic [3:0]    host_wregs = '0;
  logic          cnt_flag_o = 1'b0;
  logic          seq_en = 1'b0;
  logic [AW-1:0] seq_len = '0;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [15:0]   tbl_wdata = '0;
  logic          ovr_clr = 1'b0;

  logic [15:0]   wb_a;
  logic [7:0]    wb_b;
  logic [3:0]    wr_a, wr_b;
  logic [AW-1:0] ix_a, ix_b;
  logic          bz_a, bz_b, ov_a, ov_b;
  logic          wp_a, wp_b, iq_a, iq_b;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] m_tbl [8];
  int          m_idx [2];
  int          m_left[2];
  bit          m_busy[2];
  bit          m_ovr [2];
  bit          m_wrap[2];
  bit          m_irq [2];

  always #5 bus_clk = ~bus_clk;

  pit_reload_seq #(.COUNT_SIZE(16), .DWIDTH(16), .TBL_DEPTH(8)) dut_a (
    .bus_clk(bus_clk), .async_rst_b(async_rst_b),
    .sync_reset(sync_reset), .host_wdata(host_wdata),
    .host_wregs(host_wregs), .write_bus(wb_a), .write_regs(wr_a),
    .cnt_flag_o(cnt_flag_o), .seq_en(seq_en), .seq_len(seq_len),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .ovr_clr(ovr_clr), .seq_idx(ix_a), .seq_busy(bz_a),
    .seq_ovr(ov_a), .seq_wrap(wp_a), .seq_irq_o(iq_a)
  );

  pit_reload_seq #(.COUNT_SIZE(16), .DWIDTH(8), .TBL_DEPTH(8)) dut_b (
    .bus_clk(bus_clk), .async_rst_b(async_rst_b),
    .sync_reset(sync_reset), .host_wdata(host_wdata[7:0]),
    .host_wregs(host_wregs), .write_bus(wb_b), .write_regs(wr_b),
    .cnt_flag_o(cnt_flag_o), .seq_en(seq_en), .seq_len(seq_len),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .ovr_clr(ovr_clr), .seq_idx(ix_b), .seq_busy(bz_b),
    .seq_ovr(ov_b), .seq_wrap(wp_b), .seq_irq_o(iq_b)
  );

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = '0;
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_left[k] = 0; m_busy[k] = 0;
      m_ovr[k] = 0; m_wrap[k] = 0; m_irq[k] = 0;
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] er, eb, ent;
      ent = m_tbl[m_idx[k]];
      er = '0;
      eb = '0;
      if (host_wregs != 0) begin
        er = 16'(host_wregs);
        eb = (k == 0) ? host_wdata : {8'h00, host_wdata[7:0]};
      end else if (m_busy[k] && seq_en) begin
        if (k == 0) begin
          er = 16'h000c; eb = ent;
        end else if (m_left[k] == 2) begin
          er = 16'h0004; eb = {8'h00, ent[7:0]};
        end else begin
          er = 16'h0008; eb = {8'h00, ent[15:8]};
        end
      end
      if (k == 0) begin
        chk("a.write_regs", 16'(wr_a), er);
        chk("a.write_bus", wb_a, eb);
        chk("a.seq_idx", 16'(ix_a), 16'(m_idx[0]));
        chk("a.seq_busy", 16'(bz_a), 16'(m_busy[0]));
        chk("a.seq_ovr", 16'(ov_a), 16'(m_ovr[0]));
        chk("a.seq_wrap", 16'(wp_a), 16'(m_wrap[0]));
        chk("a.seq_irq_o", 16'(iq_a), 16'(m_irq[0]));
      end else begin
        chk("b.write_regs", 16'(wr_b), er);
        chk("b.write_bus", 16'(wb_b), eb);
        chk("b.seq_idx", 16'(ix_b), 16'(m_idx[1]));
        chk("b.seq_busy", 16'(bz_b), 16'(m_busy[1]));
        chk("b.seq_ovr", 16'(ov_b), 16'(m_ovr[1]));
        chk("b.seq_wrap", 16'(wp_b), 16'(m_wrap[1]));
        chk("b.seq_irq_o", 16'(iq_b), 16'(m_irq[1]));
      end
    end
  endtask

  // One load = a number of granted writes (1 for the 16-bit bus, 2 for
  // the 8-bit bus); the index advances when the last one is granted.
  function automatic void model_step();
    if (!async_rst_b || sync_reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      bit set_o;
      set_o = cnt_flag_o && seq_en && m_busy[k];
`ifdef PIT_SEQ_IRQ_EN
      m_irq[k] = m_wrap[k] | (m_irq[k] & !ovr_clr);
`else
      m_irq[k] = 0;
`endif
      m_ovr[k] = set_o | (m_ovr[k] & !ovr_clr);
      m_wrap[k] = 0;
      if (!seq_en) begin
        m_busy[k] = 0; m_left[k] = 0; m_idx[k] = 0;
      end else if (m_busy[k]) begin
        if (host_wregs == 0) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_busy[k] = 0;
            m_idx[k] = (m_idx[k] >= int'(seq_len)) ? 0 : m_idx[k] + 1;
            m_wrap[k] = (m_idx[k] == 0);
          end
        end
      end else if (cnt_flag_o) begin
        m_busy[k] = 1;
        m_left[k] = (k == 0) ? 1 : 2;
      end
    end
    if (tbl_we) m_tbl[tbl_addr] = tbl_wdata;
  endfunction

  task automatic tick();
    #1;
    compare_all();
    model_step();
    @(posedge bus_clk);
    @(negedge bus_clk);
  endtask

  task automatic defaults();
    cnt_flag_o = 0;
    host_wregs = '0;
    tbl_we = 0;
    ovr_clr = 0;
    sync_reset = 0;
  endtask

  initial begin
    model_reset();
    @(negedge bus_clk);
    #1;
    chk("rst.write_regs", 16'(wr_a), 16'h0);
    chk("rst.seq_idx", 16'(ix_a), 16'h0);
    chk("rst.b.seq_busy", 16'(bz_b), 16'h0);
    tick();
    async_rst_b = 1;
    tick();
    tick();

    for (int i = 0; i < 3; i++) begin
      tbl_we = 1; tbl_addr = AW'(i); tbl_wdata = 16'((i + 1) * 16);
      tick();
    end
    defaults();
    seq_len = AW'(2);
    seq_en = 1;
    tick();

    for (int r = 0; r < 3; r++) begin
      cnt_flag_o = 1;
      tick();
      defaults();
      #1;
      chk("rot.a.regs", 16'(wr_a), 16'h000c);
      chk("rot.a.bus", wb_a, 16'((r + 1) * 16));
      chk("rot.b.regs", 16'(wr_b), 16'h0004);
      chk("rot.b.bus", 16'(wb_b), 16'((r + 1) * 16));
      tick();
      #1;
      chk("rot.b.hi", 16'(wr_b), 16'h0008);
      if (r == 2) begin
        chk("wrap.a", 16'(wp_a), 16'h1);
        chk("wrap.a.idx", 16'(ix_a), 16'h0);
      end
      tick();
      if (r == 2) begin
        #1;
        chk("wrap.b", 16'(wp_b), 16'h1);
        chk("wrap.b.idx", 16'(ix_b), 16'h0);
      end
      tick();
    end
    #1;
`ifdef PIT_SEQ_IRQ_EN
    chk("irq.a.set", 16'(iq_a), 16'h1);
`else
    chk("irq.a.off", 16'(iq_a), 16'h0);
`endif

    cnt_flag_o = 1;
    tick();
    defaults();
    for (int s = 0; s < 2; s++) begin
      host_wregs = 4'b0001; host_wdata = 16'h1234;
      #1;
      chk("host.regs", 16'(wr_a), 16'h0001);
      chk("host.bus", wb_a, 16'h1234);
      tick();
    end
    defaults();
    #1;
    chk("stall.regs", 16'(wr_a), 16'h000c);
    chk("stall.bus", wb_a, 16'h0010);
    repeat (4) tick();

    tbl_we = 1; tbl_addr = AW'(1); tbl_wdata = 16'ha55a;
    tick();
    defaults();
    cnt_flag_o = 1;
    tick();
    defaults();
    #1;
    chk("b8.lo.regs", 16'(wr_b), 16'h0004);
    chk("b8.lo.bus", 16'(wb_b), 16'h005a);
    tick();
    #1;
    chk("b8.hi.regs", 16'(wr_b), 16'h0008);
    chk("b8.hi.bus", 16'(wb_b), 16'h00a5);
    tick();
    #1;
    chk("b8.idle", 16'(bz_b), 16'h0);
    tick();

    cnt_flag_o = 1;
    tick();
    defaults();
    tick();
    cnt_flag_o = 1;
    tick();
    defaults();
    #1;
    chk("ovr.set", 16'(ov_b), 16'h1);
    chk("ovr.noload", 16'(bz_b), 16'h0);
    ovr_clr = 1;
    tick();
    defaults();
    #1;
    chk("ovr.clr", 16'(ov_b), 16'h0);
    repeat (3) tick();

    cnt_flag_o = 1;
    tick();
    defaults();
    seq_en = 0;
    tick();
    #1;
    chk("en.busy", 16'(bz_b), 16'h0);
    chk("en.idx", 16'(ix_b), 16'h0);
    chk("en.regs", 16'(wr_b), 16'h0);
    seq_en = 1;
    tick();

    cnt_flag_o = 1;
    tick();
    defaults();
    #1;
    async_rst_b = 0;
    #1;
    model_reset();
    chk("arst.a.regs", 16'(wr_a), 16'h0);
    chk("arst.a.bus", wb_a, 16'h0);
    chk("arst.a.busy", 16'(bz_a), 16'h0);
    chk("arst.b.regs", 16'(wr_b), 16'h0);
    tick();
    async_rst_b = 1;
    tick();

    for (int c = 0; c < 3000; c++) begin
      cnt_flag_o = ($urandom_range(0, 5) == 0);
      host_wregs = ($urandom_range(0, 4) == 0) ?
                   4'($urandom_range(1, 15)) : 4'h0;
      host_wdata = 16'($urandom);
      if (seq_en && $urandom_range(0, 39) == 0) seq_en = 0;
      else if (!seq_en && $urandom_range(0, 4) == 0) seq_en = 1;
      if ($urandom_range(0, 49) == 0) seq_len = AW'($urandom);
      tbl_we = ($urandom_range(0, 7) == 0);
      tbl_addr = AW'($urandom);
      tbl_wdata = 16'($urandom);
      ovr_clr = ($urandom_range(0, 19) == 0);
      sync_reset = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pit_reload_seq.md
Name: pit_reload_seq

Overview:
Reload sequencer for the PIT control-register block. It holds a small table of modulo values. On each counter rollover it writes the next table entry into the PIT modulo register, using the same write_bus/write_regs strobe interface the host uses. It sits between the host register decode and the PIT register block and arbitrates that single write port; the host always wins.

Parameters:
COUNT_SIZE, 16, modulo width; only 16 supported (strobe mapping is fixed to two bytes)
DWIDTH, 16, host/PIT data bus width; 8 or 16
TBL_DEPTH, 8, number of table entries; power of two, 2..16
TBL_AW, $clog2(TBL_DEPTH), table index width (derived, not overridden)

Ports:
bus_clk  in  1  register bus clock
async_rst_b  in  1  asynchronous reset, active low
sync_reset  in  1  synchronous reset, active high
host_wdata  in  DWIDTH  host write data
host_wregs  in  4  host write strobes (PIT register encoding)
write_bus  out  DWIDTH  muxed write data to PIT registers
write_regs  out  4  muxed write strobes to PIT registers
cnt_flag_o  in  1  PIT rollover, one-cycle pulse
seq_en  in  1  sequencer enable (level)
seq_len  in  TBL_AW  index of last valid entry
tbl_we  in  1  table write strobe
tbl_addr  in  TBL_AW  table write index
tbl_wdata  in  COUNT_SIZE  table write data
ovr_clr  in  1  clear sticky overrun
seq_idx  out  TBL_AW  index of next entry to load
seq_busy  out  1  load in progress (state != IDLE)
seq_ovr  out  1  sticky: rollover missed while busy
seq_wrap  out  1  one-cycle pulse when index wraps to 0
seq_irq_o  out  1  wrap interrupt (optional feature)

Behaviour:
- Clock is bus_clk. Reset is asynchronous, active-low (async_rst_b). Both reset and sync_reset force all state to 0 and the FSM to IDLE. Table contents are also cleared.
- Arbitration is combinational:
  - host_wregs != 0: write_bus = host_wdata, write_regs = host_wregs. The sequencer stalls in its current state.
  - Otherwise the sequencer drives write_regs/write_bus in its LOAD states. All other states drive 0.
- FSM states:
  - IDLE: on cnt_flag_o && seq_en → DWIDTH 16: LOAD_W; DWIDTH 8: LOAD_LO.
  - LOAD_W: write_regs = 4'b1100, write_bus = tbl[seq_idx]. On grant (no host strobe) → IDLE and advance.
  - LOAD_LO: write_regs = 4'b0100, write_bus[7:0] = tbl[seq_idx][7:0]. On grant → LOAD_HI.
  - LOAD_HI: write_regs = 4'b1000, write_bus[7:0] = tbl[seq_idx][15:8]. On grant → IDLE and advance.
- Advance rule: seq_idx <= (seq_idx >= seq_len) ? 0 : seq_idx + 1. seq_wrap pulses for one cycle when the result is 0.
- Load latency: with no host contention, the PIT write strobe appears in the cycle after the rollover pulse (1 cycle for DWIDTH 16, 2 cycles for DWIDTH 8). Each host-strobe cycle adds exactly one stall cycle.
- Overrun: cnt_flag_o while state != IDLE (including the final grant cycle) sets seq_ovr. That pulse is dropped.
  - ovr_clr clears seq_ovr; a simultaneous set wins.
- seq_en deasserted in any state: next state IDLE, seq_idx <= 0, no further strobes. A partially written 8-bit value is left as is.
- Table writes are accepted in any state. A read of the entry being written in the same cycle returns the old value.
- seq_len changed mid-sequence: takes effect at the next advance. seq_idx > seq_len wraps to 0.
- cnt_flag_o with seq_en = 0: ignored; no overrun.

Optional Feature:
PIT_SEQ_IRQ_EN
- Defined: seq_irq_o is a registered sticky flag, set by seq_wrap and cleared by ovr_clr. Reset value is 0.
- Undefined: seq_irq_o is tied to 0 and no flop is inferred.

Decomposition:
- Package pit_seq_pkg holds:
  - state enum (IDLE, LOAD_W, LOAD_LO, LOAD_HI)
  - strobe constants WR_MOD_FULL = 4'b1100, WR_MOD_LO = 4'b0100, WR_MOD_HI = 4'b1000
- One sub-module, pit_seq_tbl: a TBL_DEPTH x COUNT_SIZE register array with one write port and one asynchronous read port.

Test Plan:
- DWIDTH 16, tbl = {0x0010, 0x0020, 0x0030}, seq_len = 2, seq_en = 1, three rollovers → write_regs = 1100 with data 0x0010, 0x0020, 0x0030 in turn. seq_wrap pulses after the third; seq_idx returns to 0.
- DWIDTH 8, tbl[0] = 0xA55A, one rollover → cycle+1: strobe 0100 with data 0x5A; cycle+2: strobe 1000 with data 0xA5; then IDLE.
- Host strobe 0001 held 2 cycles during LOAD_W → host data passes through, sequencer strobe delayed exactly 2 cycles, value unchanged.
- Second rollover during LOAD_HI → seq_ovr = 1, no extra load. ovr_clr → seq_ovr = 0.
- seq_en dropped in LOAD_LO → next cycle IDLE, seq_idx = 0, write_regs = 0. async_rst_b low mid-load → all outputs 0 immediately.
- PIT_SEQ_IRQ_EN defined, wrap → seq_irq_o = 1 until ovr_clr. Undefined → seq_irq_o stays 0.
